// File: rtl/msg_decoder.sv
// Debug message channel receiver: frames header+payload packets, buffers each one
// until complete, then replays it back-to-back. Faulty traffic is dropped and counted.
module msg_decoder #(
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 8,
  parameter int LOG_DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_msg,
  input  logic             in_nd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nd,
  output logic             out_hdr,
  output logic             error,
  output logic [15:0]      drop_count
);

  localparam int PW    = LOG_DEPTH + 1;
  localparam int DEPTH = 1 << LOG_DEPTH;

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 is_hdr, trunc, fits, we, err_d;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic [PW-1:0]        wr_base, used;
  logic [PW:0]          free;

  always_comb begin
    is_hdr  = in_msg[WIDTH-1];
    hdr_len = in_msg[LEN_WIDTH-1:0];
    // A header arriving mid-packet discards the partial packet, so space is
    // measured from the last commit point rather than the current write pointer.
    trunc   = in_nd && is_hdr && (state_q == PAYLOAD);
    wr_base = trunc ? commit_ptr_q : wr_ptr_q;
    used    = wr_base - rd_ptr_q;
    free    = (PW+1)'(DEPTH) - {1'b0, used};
    fits    = (32'(hdr_len) + 32'd1) <= 32'(free);

    state_d      = state_q;
    rem_d        = rem_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    we           = 1'b0;
    err_d        = 1'b0;

    if (in_nd) begin
      if (is_hdr) begin
        err_d    = (state_q != IDLE);
        wr_ptr_d = wr_base;
        if (fits) begin
          we       = 1'b1;
          wr_ptr_d = wr_base + 1'b1;
          if (hdr_len == '0) begin
            commit_ptr_d = wr_base + 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = PAYLOAD;
            rem_d   = hdr_len;
          end
        end else begin
          err_d   = 1'b1;
          state_d = (hdr_len == '0) ? IDLE : DROP;
          rem_d   = hdr_len;
        end
      end else begin
        case (state_q)
          IDLE: err_d = 1'b1;
          PAYLOAD: begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            rem_d    = rem_q - 1'b1;
            if (rem_q == LEN_WIDTH'(1)) begin
              commit_ptr_d = wr_ptr_q + 1'b1;
              state_d      = IDLE;
            end
          end
          DROP: begin
            rem_d = rem_q - 1'b1;
            if (rem_q == LEN_WIDTH'(1)) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_base[LOG_DEPTH-1:0]] <= in_msg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      out_data     <= '0;
      out_nd       <= 1'b0;
      out_hdr      <= 1'b0;
      error        <= 1'b0;
      drop_count   <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      error        <= err_d;
      if (err_d && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      // Reader only ever touches committed slots, so it never races the writer.
      if (rd_ptr_q != commit_ptr_q) begin
        out_data <= mem[rd_ptr_q[LOG_DEPTH-1:0]];
        out_hdr  <= mem[rd_ptr_q[LOG_DEPTH-1:0]][WIDTH-1];
        out_nd   <= 1'b1;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end else begin
        out_nd  <= 1'b0;
        out_hdr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msg_decoder.sv
// Bench for msg_decoder: directed packet scenarios plus random traffic, checked
// against a queue-based packet model (committed queue + pending packet).
module tb_msg_decoder;
  localparam int W  = 32;
  localparam int LW = 8;
  localparam int LD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_msg = '0;
  logic          in_nd = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_nd, out_hdr, error;
  logic [15:0]   drop_count;

  msg_decoder #(.WIDTH(W), .LEN_WIDTH(LW), .LOG_DEPTH(LD)) dut (
    .clk(clk), .rst(rst), .in_msg(in_msg), .in_nd(in_nd),
    .out_data(out_data), .out_nd(out_nd), .out_hdr(out_hdr),
    .error(error), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;

  // reference model
  logic [31:0] cq[$];
  logic [31:0] pend[$];
  int          mst;   // 0 idle, 1 collecting payload, 2 discarding
  int          rem;
  logic [31:0] m_data;
  logic        m_nd, m_hdr, m_err;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cq.delete(); pend.delete();
    mst = 0; rem = 0;
    m_data = '0; m_nd = 0; m_hdr = 0; m_err = 0; m_cnt = '0;
  endtask

  task automatic model_commit();
    foreach (pend[i]) cq.push_back(pend[i]);
    pend.delete();
  endtask

  task automatic model_step(input logic nd, input logic [31:0] m);
    int used, free, n;
    logic [31:0] w;
    used  = cq.size() + pend.size();
    m_err = 0;
    if (cq.size() > 0) begin
      w = cq.pop_front();
      m_data = w; m_nd = 1; m_hdr = w[31];
    end else begin
      m_nd = 0; m_hdr = 0;
    end
    if (nd) begin
      if (m[31]) begin
        if (mst != 0) m_err = 1;
        if (mst == 1) begin
          used -= pend.size();
          pend.delete();
        end
        n    = int'(m[LW-1:0]);
        free = (1 << LD) - used;
        if (n + 1 <= free) begin
          pend.push_back(m);
          if (n == 0) begin model_commit(); mst = 0; end
          else begin mst = 1; rem = n; end
        end else begin
          m_err = 1;
          mst = (n == 0) ? 0 : 2;
          rem = n;
        end
      end else begin
        case (mst)
          0: m_err = 1;
          1: begin
            pend.push_back(m);
            rem--;
            if (rem == 0) begin model_commit(); mst = 0; end
          end
          default: begin
            rem--;
            if (rem == 0) mst = 0;
          end
        endcase
      end
    end
    if (m_err && m_cnt != 16'hFFFF) m_cnt++;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, "_nd"},   32'(out_nd),     32'(m_nd));
    chk({ctx, "_hdr"},  32'(out_hdr),    32'(m_hdr));
    chk({ctx, "_data"}, out_data,        m_data);
    chk({ctx, "_err"},  32'(error),      32'(m_err));
    chk({ctx, "_cnt"},  32'(drop_count), 32'(m_cnt));
  endtask

  task automatic cyc(input logic nd, input logic [31:0] m);
    in_nd  = nd;
    in_msg = m;
    @(posedge clk);
    model_step(nd, m);
    #1;
    if (out_nd) n_out++;
    check_all("cyc");
  endtask

  task automatic do_reset();
    in_nd = 0;
    rst   = 1;
    #2;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0);
  endtask

  initial begin
    do_reset();

    // zero-length packet
    cyc(1'b1, 32'h8000_0000);
    cyc(1'b0, 32'h0);
    chk("n0_data", out_data, 32'h8000_0000);
    chk("n0_hdr", 32'(out_hdr), 32'd1);
    idle(2);

    // normal packet with type field
    do_reset();
    cyc(1'b1, 32'h8012_3403);
    cyc(1'b1, 32'h1);
    cyc(1'b1, 32'h2);
    cyc(1'b1, 32'h3);
    chk("pkt_nd_pre", 32'(out_nd), 32'd0);
    cyc(1'b0, 32'h0);
    chk("pkt_hdr_word", out_data, 32'h8012_3403);
    idle(3);
    chk("pkt_last_word", out_data, 32'h3);
    idle(2);

    // stray payload
    do_reset();
    cyc(1'b1, 32'h5);
    chk("stray_err", 32'(error), 32'd1);
    cyc(1'b0, 32'h0);
    chk("stray_cnt", 32'(drop_count), 32'd1);
    chk("stray_err_clr", 32'(error), 32'd0);

    // truncation by a new header
    do_reset();
    n_out = 0;
    cyc(1'b1, 32'h8000_0004);
    cyc(1'b1, 32'h11);
    cyc(1'b1, 32'h12);
    cyc(1'b1, 32'h8000_0001);
    cyc(1'b1, 32'h9);
    idle(4);
    chk("trunc_cnt", 32'(drop_count), 32'd1);
    chk("trunc_words", 32'(n_out), 32'd2);
    chk("trunc_last", out_data, 32'h9);

    // oversize rejection then exact-fit packet
    do_reset();
    n_out = 0;
    cyc(1'b1, 32'h8000_0008);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(i + 1));
    idle(2);
    chk("ovf_none", 32'(n_out), 32'd0);
    cyc(1'b1, 32'h8000_0007);
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'(i + 100));
    idle(10);
    chk("ovf_words", 32'(n_out), 32'd8);
    chk("ovf_cnt", 32'(drop_count), 32'd1);

    // reset mid-packet
    do_reset();
    cyc(1'b1, 32'h8000_0004);
    cyc(1'b1, 32'h21);
    do_reset();
    cyc(1'b1, 32'h22);
    cyc(1'b1, 32'h23);
    idle(2);
    chk("rst_cnt", 32'(drop_count), 32'd2);

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic nd;
      logic [31:0] m;
      nd = ($urandom % 4) != 0;
      if (($urandom % 10) < 3)
        m = {1'b1, 15'($urandom), 8'($urandom_range(0, 9))};
      else
        m = {1'b0, 31'($urandom)};
      cyc(nd, m);
      if (($urandom % 700) == 0) do_reset();
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/msg_decoder.md
Name: msg_decoder

Overview:
- Receiving end of the debug message channel (msg/msg_nd) that DSP blocks emit in DEBUG builds.
- Parses the word stream into framed packets: a header word followed by N payload words.
- Buffers each packet until it is complete, then replays it one word per cycle, so downstream logic only sees whole, well-formed packets.
- Reports framing and overflow errors and counts discarded traffic.

Parameters:
- WIDTH, 32, word width of the msg channel; must be >= LEN_WIDTH+2.
- LEN_WIDTH, 8, width of the header payload-length field.
- LOG_DEPTH, 6, log2 of buffer depth; the buffer holds 2**LOG_DEPTH words.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_msg  in  WIDTH  incoming message word.
- in_nd  in  1  in_msg valid this cycle; no backpressure.
- out_data  out  WIDTH  replayed word.
- out_nd  out  1  out_data valid.
- out_hdr  out  1  out_data is a header word (qualified by out_nd).
- error  out  1  one-cycle pulse on any framing or overflow fault.
- drop_count  out  16  saturating count of error cycles.

Behaviour:
- Word format:
  - bit WIDTH-1 = 1 marks a header; = 0 marks a payload word.
  - Header bits [LEN_WIDTH-1:0] give N, the payload length (0..2**LEN_WIDTH-1).
  - Header bits [WIDTH-2:LEN_WIDTH] carry the message type and are passed through unchanged.
- Reset: all of the following are 0 immediately, independent of clk:
  - out_data, out_nd, out_hdr, error, drop_count;
  - wr_ptr, commit_ptr, rd_ptr (each LOG_DEPTH+1 bits);
  - state = IDLE.
- Free-space calculation:
  - free = 2**LOG_DEPTH - (wr_ptr - rd_ptr), using modulo-2**(LOG_DEPTH+1) arithmetic.
  - used includes uncommitted words.
- States: IDLE, PAYLOAD (remaining-count register), DROP (remaining-count register). Only cycles with in_nd=1 are acted on; in_nd=0 holds state.
- IDLE:
  - Header with N+1 <= free: write the header.
    - N=0: commit immediately, commit_ptr = wr_ptr+1; stay in IDLE.
    - N>0: go to PAYLOAD with remaining = N.
  - Header with N+1 > free: error; enter DROP with remaining = N (IDLE if N=0). Nothing is written.
  - Payload word (stray): error; word discarded.
- PAYLOAD:
  - Payload word: write it and decrement remaining.
  - When remaining reaches 0: commit_ptr = new wr_ptr; go to IDLE.
  - Header (truncation): error; rewind wr_ptr = commit_ptr. The same header is then handled as in IDLE, with free recomputed after the rewind.
- DROP:
  - Payload word: discard and decrement; at 0 go to IDLE.
  - Header: error; the header is handled as in IDLE.
- Reader:
  - Each cycle with rd_ptr != commit_ptr: register the word into out_data, set out_nd=1, set out_hdr = bit WIDTH-1, and increment rd_ptr.
  - Otherwise out_nd=0 and out_hdr=0; out_data holds its last value.
  - Reading and writing proceed concurrently in the same cycle without conflict.
- Latency:
  - Commit occurs on the edge that samples the last word of the packet (or the header when N=0).
  - The header appears with out_nd=1 after the following edge, then payload words on consecutive cycles with no gaps.
- Error and drop_count:
  - error is registered, high for exactly one cycle per faulting input cycle.
  - Multiple causes in one cycle (truncation plus rejection of the new header) produce a single pulse.
  - drop_count increments by 1 per error cycle and saturates at 0xFFFF.
- Full buffer: accepted packets never overflow, because space is reserved at header time. A packet with N+1 > 2**LOG_DEPTH is always rejected.
- Wrap-around: pointers wrap naturally. Full is wr_ptr - rd_ptr = 2**LOG_DEPTH; empty for reading is rd_ptr = commit_ptr.
- Reset mid-packet: uncommitted and unread data is lost. After reset the block is in IDLE, so leading payload words are stray and each raises error.

Test Plan:
- Header 0x8000_0000 (N=0), single in_nd -> after 2 edges: out_nd=1, out_hdr=1, out_data=0x8000_0000 for one cycle; error stays 0.
- Header 0x8012_3403 followed by payloads 1, 2, 3 on consecutive cycles -> outputs 0x8012_3403 (out_hdr=1), then 1, 2, 3 (out_hdr=0) back-to-back, starting the cycle after the commit edge.
- Payload 0x5 while IDLE -> error pulse of 1 cycle, drop_count=1, no output.
- Header N=4, two payloads, then header N=1 and payload 9 -> error pulse once, drop_count=1, output is only the N=1 header followed by 9.
- LOG_DEPTH=3:
  - Header N=8 -> rejected; error pulses; the 8 following payloads produce no output.
  - Then header N=7 plus 7 payloads -> 8 words output.
- Assert rst mid-PAYLOAD, release, send 2 payloads -> outputs go to 0 asynchronously; 2 error pulses; drop_count=2.
